// File: rtl/mux_src_arbiter.sv
// Round-robin owner of the shared MUX2TO1 datapath: picks s for two requesters,
// captures the mux output and offers it downstream on a valid/ready port.
module mux_src_arbiter #(
    parameter int WIDTH = 16,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] mux_out,
    input  logic             out_ready,
    output logic             s,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [1:0]       dbg_state
);

    // Handshake: a word on data_out is consumed on any rising edge where
    // data_valid=1 and out_ready=1; data_out is stable while data_valid=1 and out_ready=0.

    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_owner;

    logic          in_own;
    logic          own;
    logic          req_own;
    logic          req_oth;
    logic          xfer;
    logic          drain;
    logic [CW-1:0] count_inc;
    logic          dwell_hit;

    always_comb begin
        in_own    = (state == OWN0) || (state == OWN1);
        own       = (state == OWN1);
        req_own   = own ? req1 : req0;
        req_oth   = own ? req0 : req1;
        xfer      = in_own && req_own && (!data_valid || out_ready);
        drain     = data_valid && out_ready && !xfer;
        count_inc = count + CW'(1);
        dwell_hit = xfer && (count_inc == CW'(DWELL));
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            s          <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            count      <= '0;
            last_owner <= 1'b1;
        end else begin
            if (xfer) begin
                data_out   <= mux_out;
                data_valid <= 1'b1;
            end else if (drain) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // last_owner=1 means source 0 wins a tie
                    if (req0 && (!req1 || last_owner)) begin
                        state <= OWN0;
                        s     <= 1'b0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                    end else if (req1) begin
                        state <= OWN1;
                        s     <= 1'b1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!req_own || (dwell_hit && req_oth)) begin
                        count      <= '0;
                        last_owner <= own;
                        if (req_oth) begin
                            state <= own ? OWN0 : OWN1;
                            s     <= !own;
                            gnt0  <= own;
                            gnt1  <= !own;
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                        end
                    end else if (dwell_hit) begin
                        // Nobody else waiting: keep the grant, start a fresh dwell window
                        count <= '0;
                    end else if (xfer) begin
                        count <= count_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Bench for mux_src_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an owner/queue model.
module tb_mux_src_arbiter;

    localparam int WIDTH = 16;
    localparam int DWELL = 4;

    logic             clk;
    logic             reset_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] mux_out;
    logic             out_ready;
    logic             s;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [1:0]       dbg_state;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // External MUX2TO1 driven by the DUT select
    assign mux_out = s ? in2 : in1;

    mux_src_arbiter #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .mux_out    (mux_out),
        .out_ready  (out_ready),
        .s          (s),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .data_out   (data_out),
        .data_valid (data_valid),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int               m_own  = -1;   // -1: nobody owns the mux
    int               m_cnt  = 0;
    bit               m_s    = 1'b0;
    bit               m_dv   = 1'b0;
    bit               m_last = 1'b1;
    logic [WIDTH-1:0] m_dout = '0;
    logic [WIDTH-1:0] exp_q[$];      // words captured but not yet consumed

    always @(posedge clk) begin
        bit               fire;
        bit               rx;
        bit               ry;
        int               x;
        logic [WIDTH-1:0] word;
        if (!reset_n) begin
            m_own  = -1;
            m_cnt  = 0;
            m_s    = 1'b0;
            m_dv   = 1'b0;
            m_last = 1'b1;
            m_dout = '0;
            exp_q.delete();
        end else begin
            rx   = (m_own == 0) ? req0 : req1;
            ry   = (m_own == 0) ? req1 : req0;
            fire = (m_own >= 0) && rx && (!m_dv || out_ready);
            if (m_dv && out_ready) begin
                void'(exp_q.pop_front());
                m_dv = 1'b0;
            end
            if (fire) begin
                word   = m_s ? in2 : in1;
                m_dout = word;
                m_dv   = 1'b1;
                exp_q.push_back(word);
            end
            if (m_own < 0) begin
                if (req0 || req1) begin
                    x     = (req0 && req1) ? (m_last ? 0 : 1) : (req0 ? 0 : 1);
                    m_own = x;
                    m_s   = (x == 1);
                    m_cnt = 0;
                end
            end else if (!rx) begin
                m_cnt  = 0;
                m_last = (m_own == 1);
                if (ry) begin
                    m_own = 1 - m_own;
                    m_s   = (m_own == 1);
                end else begin
                    m_own = -1;
                end
            end else if (fire) begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_cnt = 0;
                    if (ry) begin
                        m_last = (m_own == 1);
                        m_own  = 1 - m_own;
                        m_s    = (m_own == 1);
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        check("gnt0", 32'(gnt0), 32'(m_own == 0));
        check("gnt1", 32'(gnt1), 32'(m_own == 1));
        check("s", 32'(s), 32'(m_s));
        check("data_valid", 32'(data_valid), 32'(exp_q.size() != 0));
        check("data_out", 32'(data_out), 32'((exp_q.size() != 0) ? exp_q[0] : m_dout));
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        compare_model();
        n_vec++;
    endtask

    task automatic drive(input logic rn, input logic r0, input logic r1, input logic rdy);
        reset_n   = rn;
        req0      = r0;
        req1      = r1;
        out_ready = rdy;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_d;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        in1 = 16'hA5A5;
        in2 = 16'h5A5A;

        // Reset held with both requests up
        repeat (3) cycle();
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);

        // Single requester: grant, then first word
        in2 = 16'h1234;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        check("single_gnt0", 32'(gnt0), 32'd1);
        check("single_dv0", 32'(data_valid), 32'd0);
        cycle();
        check("single_dout", 32'(data_out), 32'hA5A5);
        check("single_dv1", 32'(data_valid), 32'd1);
        check("single_s", 32'(s), 32'd0);
        check("single_gnt1", 32'(gnt1), 32'd0);

        // Both requesting: DWELL words each, alternating
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        in2 = 16'h5A5A;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            check("rr_gnt1", 32'(gnt1), 32'((c >= 5) && (c <= 8)));
            check("rr_model_gnt1", 32'(m_own == 1), 32'((c >= 5) && (c <= 8)));
            if (c >= 2) begin
                exp_d = ((c >= 6) && (c <= 9)) ? 16'h5A5A : 16'hA5A5;
                check("rr_dout", 32'(data_out), 32'(exp_d));
            end
        end

        // Downstream stall: word held, no switch, dwell count frozen
        in1 = 16'h1111;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("stall_dout", 32'(data_out), 32'hA5A5);
            check("stall_gnt0", 32'(gnt0), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("resume_dout", 32'(data_out), 32'h1111);
        check("resume_gnt1", 32'(gnt1), 32'd1);

        // Owner drops its request
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        check("drop_gnt0", 32'(gnt0), 32'd1);
        check("drop_gnt1", 32'(gnt1), 32'd0);
        check("drop_s0", 32'(s), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        check("idle_gnt0", 32'(gnt0), 32'd0);
        check("idle_gnt1", 32'(gnt1), 32'd0);
        check("idle_s_hold", 32'(s), 32'd1);

        // Reset while source 1 owns the mux with a word pending
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        check("pre_rst_dv", 32'(data_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("mid_rst_gnt1", 32'(gnt1), 32'd0);
        check("mid_rst_dv", 32'(data_valid), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        check("post_rst_gnt0", 32'(gnt0), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            out_ready = ($urandom_range(0, 3) != 0);
            in1 = WIDTH'($urandom);
            in2 = WIDTH'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
